// File: rtl/seg_disp_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed 7-segment display.
package seg_disp_pkg;

  typedef enum logic {BLANK, ON} scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Returns active-high {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_seg(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h67;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h58;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex digit to active-low segment pattern for a common-anode display.
module hex_seg_decode
  import seg_disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  assign seg_n = ~hex_seg(hex);

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit common-anode scan driver: frame-synchronous digit update, anode dead-time,
// PWM brightness and optional leading-zero blanking. Outputs are registered.
module seg_scan_driver
  import seg_disp_pkg::*;
#(
  parameter int SLOT_EXP     = 16,
  parameter int BLANK_CYCLES = 64,
  parameter int PWM_BITS     = 4,
  parameter int BLANK_LEAD   = 1
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [3:0]          s1,
  input  logic [3:0]          s2,
  input  logic                load,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                blank_all,
  output logic [6:0]          seg,
  output logic                anode1_en,
  output logic                anode2_en,
  output logic                frame_start
);

  localparam logic [SLOT_EXP-1:0] BLANK_CNT = SLOT_EXP'(BLANK_CYCLES);

  logic [SLOT_EXP-1:0] cnt;
  logic [SLOT_EXP-1:0] cnt_next;
  logic                slot;
  scan_state_t         state;
  scan_state_t         state_next;
  logic [3:0]          disp1;
  logic [3:0]          disp2;
  logic [3:0]          pend1;
  logic [3:0]          pend2;
  logic                pend_v;
  logic                wrap;
  logic                boundary;
  logic                lead_blank;
  logic                lit;
  logic [PWM_BITS-1:0] phase;
  logic [3:0]          cur_digit;
  logic [6:0]          cur_seg_n;

  hex_seg_decode u_dec (
    .hex   (cur_digit),
    .seg_n (cur_seg_n)
  );

  // State is derived from the count it will hold next, so it always matches cnt.
  always_comb begin
    cnt_next   = cnt + SLOT_EXP'(1);
    wrap       = (cnt == '1);
    boundary   = wrap & slot;
    state_next = (cnt_next < BLANK_CNT) ? BLANK : ON;
    phase      = cnt[PWM_BITS-1:0];
    lead_blank = (BLANK_LEAD != 0) && !slot && (disp1 == 4'h0);
    lit        = (state == ON) && (phase <= brightness) && !blank_all && !lead_blank;
    cur_digit  = slot ? disp2 : disp1;
  end

  always_ff @(posedge clk) begin
    if (!nreset) state <= BLANK;
    else         state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt  <= '0;
      slot <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (wrap) slot <= ~slot;
    end
  end

  // A load on the boundary bypasses the pending registers so no stale frame is shown.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      disp1  <= '0;
      disp2  <= '0;
      pend1  <= '0;
      pend2  <= '0;
      pend_v <= 1'b0;
    end else if (boundary) begin
      pend_v <= 1'b0;
      if (load) begin
        disp1 <= s1;
        disp2 <= s2;
        pend1 <= s1;
        pend2 <= s2;
      end else if (pend_v) begin
        disp1 <= pend1;
        disp2 <= pend2;
      end
    end else if (load) begin
      pend1  <= s1;
      pend2  <= s2;
      pend_v <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      seg         <= SEG_OFF;
      anode1_en   <= 1'b0;
      anode2_en   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      seg         <= lit ? cur_seg_n : SEG_OFF;
      anode1_en   <= lit & ~slot;
      anode2_en   <= lit & slot;
      frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SLOT_EXP=4, BLANK_CYCLES=2, PWM_BITS=2, BLANK_LEAD=1.
module tb_seg_scan_driver;

  logic       clk;
  logic       nreset;
  logic [3:0] s1;
  logic [3:0] s2;
  logic       load;
  logic [1:0] brightness;
  logic       blank_all;
  logic [6:0] seg;
  logic       anode1_en;
  logic       anode2_en;
  logic       frame_start;

  int n_checks;
  int n_pass;
  int k;

  seg_scan_driver #(
    .SLOT_EXP     (4),
    .BLANK_CYCLES (2),
    .PWM_BITS     (2),
    .BLANK_LEAD   (1)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .s1          (s1),
    .s2          (s2),
    .load        (load),
    .brightness  (brightness),
    .blank_all   (blank_all),
    .seg         (seg),
    .anode1_en   (anode1_en),
    .anode2_en   (anode2_en),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s (k=%0d): got %0h expected %0h", tag, k, got, exp);
    else
      n_pass++;
  endtask

  task automatic expect_out(input string tag, input logic a1, input logic a2, input logic [6:0] sg);
    check({tag, ".anode1"}, 32'(anode1_en), 32'(a1));
    check({tag, ".anode2"}, 32'(anode2_en), 32'(a2));
    check({tag, ".seg"},    32'(seg),       32'(sg));
  endtask

  // k = posedges since reset release; observations happen on the falling edge.
  task automatic step_to(input int target);
    while (k < target) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cs;
    int on_cnt;
    logic on;
    n_checks   = 0;
    n_pass     = 0;
    k          = 0;
    nreset     = 1'b0;
    load       = 1'b0;
    s1         = 4'h0;
    s2         = 4'h0;
    brightness = 2'd3;
    blank_all  = 1'b0;

    @(negedge clk);
    expect_out("rst_a", 1'b0, 1'b0, 7'h7F);
    check("rst_fs", 32'(frame_start), 32'd0);
    @(negedge clk);
    expect_out("rst_b", 1'b0, 1'b0, 7'h7F);
    nreset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step_to(i);
      expect_out("post_rst", 1'b0, 1'b0, 7'h7F);
    end

    step_to(8);
    load = 1'b1; s1 = 4'h3; s2 = 4'hA;
    step_to(9);
    load = 1'b0;
    step_to(10);
    expect_out("held_slot0", 1'b0, 1'b0, 7'h7F);
    step_to(16);
    check("slot_wrap_fs", 32'(frame_start), 32'd0);
    step_to(20);
    expect_out("held_slot1", 1'b0, 1'b1, 7'h40);
    step_to(31);
    check("pre_frame_fs", 32'(frame_start), 32'd0);
    step_to(32);
    check("frame_fs", 32'(frame_start), 32'd1);
    step_to(33);
    expect_out("dead0", 1'b0, 1'b0, 7'h7F);
    check("fs_one_cycle", 32'(frame_start), 32'd0);
    step_to(34);
    expect_out("dead1", 1'b0, 1'b0, 7'h7F);
    step_to(35);
    expect_out("first_on", 1'b1, 1'b0, 7'b0110000);
    step_to(37);
    expect_out("dig3", 1'b1, 1'b0, 7'b0110000);
    step_to(53);
    expect_out("digA", 1'b0, 1'b1, 7'b0001000);

    step_to(55);
    load = 1'b1; s1 = 4'h1; s2 = 4'h2;
    step_to(56);
    load = 1'b0;

    step_to(64);
    brightness = 2'd0;
    load = 1'b1; s1 = 4'h0; s2 = 4'h5;
    step_to(65);
    load = 1'b0;
    on_cnt = 0;
    for (int i = 65; i <= 80; i++) begin
      step_to(i);
      cs = i - 65;
      on = (cs >= 2) && (cs % 4 == 0);
      expect_out("pwm0_slot0", on, 1'b0, on ? 7'h79 : 7'h7F);
      if (anode1_en) on_cnt++;
    end
    check("pwm0_count0", 32'(on_cnt), 32'd3);
    on_cnt = 0;
    for (int i = 81; i <= 96; i++) begin
      step_to(i);
      cs = i - 81;
      on = (cs >= 2) && (cs % 4 == 0);
      expect_out("pwm0_slot1", 1'b0, on, on ? 7'h24 : 7'h7F);
      if (anode2_en) on_cnt++;
    end
    check("pwm0_count1", 32'(on_cnt), 32'd3);

    brightness = 2'd3;
    for (int i = 97; i <= 112; i++) begin
      step_to(i);
      expect_out("lead_blank", 1'b0, 1'b0, 7'h7F);
    end
    load = 1'b1; s1 = 4'h9; s2 = 4'h9;
    step_to(113);
    load = 1'b0;
    step_to(115);
    expect_out("dig5_a", 1'b0, 1'b1, 7'b0010010);
    step_to(117);
    expect_out("dig5_b", 1'b0, 1'b1, 7'b0010010);

    step_to(127);
    load = 1'b1; s1 = 4'h7; s2 = 4'h8;
    step_to(128);
    load = 1'b0;
    check("bnd_load_fs", 32'(frame_start), 32'd1);
    step_to(133);
    expect_out("bnd_dig7", 1'b1, 1'b0, 7'b1111000);
    step_to(149);
    expect_out("bnd_dig8", 1'b0, 1'b1, 7'b0000000);
    step_to(160);
    check("idle_frame_fs", 32'(frame_start), 32'd1);
    step_to(165);
    expect_out("no_stale", 1'b1, 1'b0, 7'b1111000);

    step_to(166);
    expect_out("pre_blank", 1'b1, 1'b0, 7'b1111000);
    blank_all = 1'b1;
    step_to(167);
    expect_out("blank_all", 1'b0, 1'b0, 7'h7F);
    blank_all = 1'b0;
    step_to(168);
    expect_out("unblank", 1'b1, 1'b0, 7'b1111000);

    step_to(180);
    expect_out("pre_reset", 1'b0, 1'b1, 7'b0000000);
    nreset = 1'b0;
    step_to(181);
    expect_out("mid_reset", 1'b0, 1'b0, 7'h7F);
    check("mid_reset_fs", 32'(frame_start), 32'd0);
    nreset = 1'b1;
    k = 0;
    step_to(3);
    expect_out("rst2_slot0", 1'b0, 1'b0, 7'h7F);
    step_to(21);
    expect_out("rst2_disp0", 1'b0, 1'b1, 7'h40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
